sigma_delta_decimator: RTL and testbench

Downstream companion of `sigma_delta_core`. It consumes the 1-bit `sigma_delta` stream and counts ones over fixed, back-to-back windows of 2**DECIM_LOG2 enabled cycles. At each window boundary it produces a VALUE_WIDTH-bit reconstructed value on a valid/ready output port. In loopback, the core's input `value` is recovered exactly for any constant input held across a window. The block is the hardware form of the bench-side integrator check and the demodulation path for on-chip self-test.

---
 rtl/sigma_delta_decimator.sv | 117 +++++++++++
 tb/tb_sigma_delta_decimator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_decimator.sv
// sigma_delta_decimator
// Counts ones of a 1-bit sigma-delta stream over back-to-back windows of
// 2**DECIM_LOG2 enabled cycles and publishes the scaled, saturated count on a
// valid/ready port. A result that is overwritten before acceptance sets a
// sticky overrun flag.
module sigma_delta_decimator #(
  parameter int VALUE_WIDTH = 8,
  parameter int DECIM_LOG2  = VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sigma_delta,
  output logic [VALUE_WIDTH-1:0] out_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun
);

  // The window must hold at least 2**VALUE_WIDTH samples so the right shift
  // below never has a negative amount.
  if (DECIM_LOG2 < VALUE_WIDTH) begin : g_param_check
    $error("sigma_delta_decimator: DECIM_LOG2 must be >= VALUE_WIDTH");
  end

  localparam int                    SHIFT    = DECIM_LOG2 - VALUE_WIDTH;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = {DECIM_LOG2{1'b1}};
  localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1'b1);

  // Clamp the scaled count into VALUE_WIDTH bits; only a window of all ones
  // can exceed the range (total = 2**DECIM_LOG2).
  function automatic logic [VALUE_WIDTH-1:0] saturate(input logic [DECIM_LOG2:0] scaled);
    logic [VALUE_WIDTH-1:0] res;
    if (|scaled[DECIM_LOG2:VALUE_WIDTH]) begin
      res = {VALUE_WIDTH{1'b1}};
    end else begin
      res = scaled[VALUE_WIDTH-1:0];
    end
    return res;
  endfunction

  logic [DECIM_LOG2-1:0]  win_cnt_r;
  logic [DECIM_LOG2:0]    acc_r;
  logic [VALUE_WIDTH-1:0] result_r;
  logic                   valid_r;
  logic                   overrun_r;

  logic                   window_last_s;
  logic [DECIM_LOG2:0]    total_s;
  logic [DECIM_LOG2:0]    scaled_s;
  logic [VALUE_WIDTH-1:0] result_sat_s;
  logic                   accept_s;
  logic                   overrun_hit_s;

  // Window completion detection, count scaling and handshake decode.
  always_comb begin
    window_last_s = 1'b0;
    total_s       = acc_r + {{DECIM_LOG2{1'b0}}, sigma_delta};
    scaled_s      = total_s >> SHIFT;
    result_sat_s  = saturate(scaled_s);
    accept_s      = valid_r & out_ready;
    overrun_hit_s = 1'b0;
    if (enable && (win_cnt_r == CNT_LAST)) begin
      window_last_s = 1'b1;
      overrun_hit_s = valid_r & ~out_ready;
    end else begin
      window_last_s = 1'b0;
      overrun_hit_s = 1'b0;
    end
  end

  // Window position and ones accumulator; a disabled cycle discards the
  // partial window so re-enable always starts a fresh one.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_r <= {DECIM_LOG2{1'b0}};
      acc_r     <= {(DECIM_LOG2+1){1'b0}};
    end else if (enable) begin
      win_cnt_r <= win_cnt_r + CNT_ONE;
      if (window_last_s) begin
        acc_r <= {(DECIM_LOG2+1){1'b0}};
      end else begin
        acc_r <= total_s;
      end
    end else begin
      win_cnt_r <= {DECIM_LOG2{1'b0}};
      acc_r     <= {(DECIM_LOG2+1){1'b0}};
    end
  end

  // Result register, valid flag and sticky overrun; a completion always wins
  // over a same-cycle acceptance so the newest result is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r  <= {VALUE_WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (window_last_s) begin
      result_r  <= result_sat_s;
      valid_r   <= 1'b1;
      overrun_r <= overrun_r | overrun_hit_s;
    end else if (accept_s) begin
      result_r  <= result_r;
      valid_r   <= 1'b0;
      overrun_r <= overrun_r;
    end else begin
      result_r  <= result_r;
      valid_r   <= valid_r;
      overrun_r <= overrun_r;
    end
  end

  assign out_value = result_r;
  assign out_valid = valid_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Self-checking bench: two decimators (DECIM_LOG2 = 8 and 10) driven with the
// same stimulus and compared every cycle against a window-counting model.
module tb_sigma_delta_decimator;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sigma_delta;
  logic       out_ready;
  logic [7:0] out_value8,  out_value10;
  logic       out_valid8,  out_valid10;
  logic       overrun8,    overrun10;

  int n_checks = 0;
  int n_fail   = 0;

  // model state, index 0: 256-sample window, index 1: 1024-sample window
  int m_n[2];
  int m_ones[2];
  int m_val[2];
  bit m_valid[2];
  bit m_ovr[2];

  logic [7:0] lb_acc = 8'd0;

  always #5 clk = ~clk;

  sigma_delta_decimator #(.VALUE_WIDTH(8), .DECIM_LOG2(8)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .sigma_delta(sigma_delta),
    .out_value(out_value8), .out_valid(out_valid8), .out_ready(out_ready),
    .overrun(overrun8));

  sigma_delta_decimator #(.VALUE_WIDTH(8), .DECIM_LOG2(10)) u_dut10 (
    .clk(clk), .reset(reset), .enable(enable), .sigma_delta(sigma_delta),
    .out_value(out_value10), .out_valid(out_valid10), .out_ready(out_ready),
    .overrun(overrun10));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one rising edge as seen by the model: count ones per window, publish
  // min(ones >> shift, 255) when the window fills
  task automatic model_step(input bit en, input bit sd, input bit rdy, input bit rst);
    for (int i = 0; i < 2; i++) begin
      int  win;
      int  sh;
      int  v;
      bit  done;
      win  = (i == 0) ? 256 : 1024;
      sh   = (i == 0) ? 0 : 2;
      done = 1'b0;
      v    = 0;
      if (rst) begin
        m_n[i] = 0; m_ones[i] = 0; m_val[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
      end else begin
        if (en) begin
          m_ones[i] += int'(sd);
          m_n[i]++;
          if (m_n[i] == win) begin
            done = 1'b1;
            v = m_ones[i] >> sh;
            if (v > 255) v = 255;
            m_n[i] = 0;
            m_ones[i] = 0;
          end
        end else begin
          m_n[i] = 0;
          m_ones[i] = 0;
        end
        if (done) begin
          if (m_valid[i] && !rdy) m_ovr[i] = 1'b1;
          m_val[i] = v;
          m_valid[i] = 1'b1;
        end else if (m_valid[i] && rdy) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit en, input bit sd, input bit rdy, input bit rst);
    enable = en; sigma_delta = sd; out_ready = rdy; reset = rst;
    @(posedge clk);
    model_step(en, sd, rdy, rst);
    #1;
    check_eq("value8",   32'(out_value8),  32'(m_val[0]));
    check_eq("valid8",   32'(out_valid8),  32'(m_valid[0]));
    check_eq("overrun8", 32'(overrun8),    32'(m_ovr[0]));
    check_eq("value10",  32'(out_value10), 32'(m_val[1]));
    check_eq("valid10",  32'(out_valid10), 32'(m_valid[1]));
    check_eq("overrun10",32'(overrun10),   32'(m_ovr[1]));
  endtask

  // emulated first-order modulator looped into both decimators
  task automatic run_lb(input logic [7:0] v, input int n, input bit rdy);
    logic [8:0] s;
    for (int k = 0; k < n; k++) begin
      s = {1'b0, lb_acc} + {1'b0, v};
      lb_acc = s[7:0];
      cyc(1'b1, s[8], rdy, 1'b0);
    end
  endtask

  task automatic run_const(input bit sd, input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, sd, 1'b1, 1'b0);
  endtask

  int n;
  logic [7:0] lb_vals [3];

  initial begin
    lb_vals[0] = 8'd77; lb_vals[1] = 8'd173; lb_vals[2] = 8'd0;
    enable = 1'b0; sigma_delta = 1'b0; out_ready = 1'b0; reset = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("rst_value8", 32'(out_value8), 32'd0);
    check_eq("rst_valid8", 32'(out_valid8), 32'd0);
    check_eq("rst_ovr8",   32'(overrun8),   32'd0);

    // constant zero stream
    run_const(1'b0, 1024);
    check_eq("zero_value8",  32'(out_value8),  32'd0);
    check_eq("zero_value10", 32'(out_value10), 32'd0);
    check_eq("zero_ovr8",    32'(overrun8),    32'd0);

    // constant one stream saturates
    run_const(1'b1, 1024);
    check_eq("ones_value8",  32'(out_value8),  32'd255);
    check_eq("ones_value10", 32'(out_value10), 32'd255);

    // loopback recovery
    for (int j = 0; j < 3; j++) begin
      run_lb(lb_vals[j], 1024, 1'b1);
      check_eq("lb_value8",  32'(out_value8),  32'(lb_vals[j]));
      check_eq("lb_value10", 32'(out_value10), 32'(lb_vals[j]));
    end

    // pattern 1000
    for (int k = 0; k < 1024; k++) cyc(1'b1, (k % 4) == 0, 1'b1, 1'b0);
    check_eq("p1000_value10", 32'(out_value10), 32'd64);
    check_eq("p1000_value8",  32'(out_value8),  32'd64);

    // randomized traffic with enable drops, back-pressure and rare resets
    for (int k = 0; k < 4000; k++) begin
      cyc($urandom_range(0, 63) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
    end

    // enable drop mid-window discards the partial window
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 500; k++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    n = 0;
    do begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n++;
    end while (!out_valid10 && n < 1100);
    check_eq("reenable_latency10", 32'(n), 32'd1024);

    // overrun: two windows without acceptance
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    run_lb(8'd40, 256, 1'b0);
    run_lb(8'd200, 256, 1'b0);
    check_eq("ovr_valid8", 32'(out_valid8), 32'd1);
    check_eq("ovr_value8", 32'(out_value8), 32'd200);
    check_eq("ovr_flag8",  32'(overrun8),   32'd1);

    // reset mid-window while a result is pending
    run_lb(8'd90, 100, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("midrst_value8", 32'(out_value8), 32'd0);
    check_eq("midrst_valid8", 32'(out_valid8), 32'd0);
    check_eq("midrst_ovr8",   32'(overrun8),   32'd0);
    n = 0;
    do begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      n++;
    end while (!out_valid8 && n < 300);
    check_eq("post_rst_latency8", 32'(n), 32'd256);

    // ready raised exactly on B's completing cycle
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    run_lb(8'd40, 256, 1'b0);
    run_lb(8'd200, 255, 1'b0);
    run_lb(8'd200, 1, 1'b1);
    check_eq("same_cyc_valid8", 32'(out_valid8), 32'd1);
    check_eq("same_cyc_value8", 32'(out_value8), 32'd200);
    check_eq("same_cyc_ovr8",   32'(overrun8),   32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("accept_valid8", 32'(out_valid8), 32'd0);
    check_eq("accept_value8", 32'(out_value8), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
